iot_event_encoder: RTL

IOT_EVENT_ENCODER -- requirements
Module: iot_event_encoder

---
 rtl/iot_event_encoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/iot_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : iot_event_encoder
// Purpose  : Watches N_DEV device on/off levels and turns every level change
//            into a single-cycle event (change/on_off/dev_id), one device per
//            cycle, chosen round-robin. Keeps a shadow of the downstream
//            "devices on" counter.
// Ports    : clk          - clock, rising edge
//            rst          - synchronous active-high reset
//            dev_status   - per-device level, 1 = on
//            hold         - downstream stall, no event issued while high
//            change       - registered event strobe
//            on_off       - registered event direction (1 = turned on)
//            dev_id       - registered index of the reported device
//            busy         - some device has an unreported transition
//            shadow_count - registered count of devices reported on
// Revision : 1.0 - initial release
// ============================================================================
module iot_event_encoder #(
  parameter int N_DEV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [4:0]       dev_id,
  output logic             busy,
  output logic [7:0]       shadow_count
);

  localparam int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [PTR_W:0]   C_N_EXT = (PTR_W + 1)'(N_DEV);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(N_DEV - 1);

  logic [N_DEV-1:0] status_q;
  logic [N_DEV-1:0] reported;
  logic [N_DEV-1:0] pending;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] win;
  logic             found;
  logic             issue;
  logic [PTR_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;

  // A device is pending while its sampled level differs from what was last
  // reported; toggling back before winning cancels the transition for free.
  assign pending = status_q ^ reported;
  assign busy    = |pending;

  // Round-robin search: scan offsets 0..N_DEV-1 from ptr, wrapping at N_DEV,
  // and keep the first pending index encountered.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < N_DEV; k++) begin
      idx_sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx_sum >= C_N_EXT) begin
        idx_sum = idx_sum - C_N_EXT;
      end
      idx = idx_sum[PTR_W-1:0];
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign issue   = found & ~hold;
  assign ptr_nxt = (win == C_LAST) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q     <= '0;
      reported     <= '0;
      ptr          <= '0;
      change       <= 1'b0;
      on_off       <= 1'b0;
      dev_id       <= '0;
      shadow_count <= '0;
    end else begin
      status_q <= dev_status;
      change   <= issue;
      on_off   <= issue & status_q[win];
      dev_id   <= issue ? 5'(win) : 5'd0;
      if (issue) begin
        reported[win] <= status_q[win];
        ptr           <= ptr_nxt;
        // Same edge as the event, so a downstream counter stays in lockstep.
        if (status_q[win]) begin
          shadow_count <= shadow_count + 8'd1;
        end else begin
          shadow_count <= shadow_count - 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
